// File: rtl/proj_errmon_pkg.sv
// Shared definitions for the lane error monitor: FSM encodings, clog2 and the
// unlit LED pattern helper.
package proj_errmon_pkg;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_ALARM = 1'b1;

    localparam int MAXLW = 64;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // All-unlit LED word for up to MAXLW lanes; callers cast down to their width.
    function automatic logic [MAXLW-1:0] unlit_pat(input int lw, input bit actlow);
        logic [MAXLW-1:0] p;
        p = '0;
        for (int i = 0; i < MAXLW; i++) begin
            if (i < lw) p[i] = actlow;
        end
        return p;
    endfunction

endpackage

// File: rtl/proj_errmon_sync.sv
// SYNC-deep single-bit synchroniser; reset clears every stage.
module proj_errmon_sync
    import proj_errmon_pkg::*;
#(
    parameter int SYNC = 2
)(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC-1:0] r_chain;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC-2:0], i_d};
        end
    end

    assign o_q = r_chain[SYNC-1];

endmodule

// File: rtl/proj_errmon.sv
// Lane error monitor: synchronised sticky flags, per-lane event counters and LED
// heartbeat/alarm display. Counters are built only when PROJ_ERRMON_CNT_EN is defined.
module proj_errmon
    import proj_errmon_pkg::*;
#(
    parameter int LW     = 8,
    parameter int SYNC   = 2,
    parameter int HBW    = 24,
    parameter int CW     = 8,
    parameter bit ACTLOW = 1'b1,
    // One extra select bit so out-of-range lanes (>= LW) are expressible.
    localparam int SELW  = clog2(LW + 1)
)(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [LW-1:0]   i_errflg,
    input  logic            i_clr,
    input  logic [SELW-1:0] i_cntsel,
    output logic [CW-1:0]   o_cntval,
    output logic            o_errany,
    output logic [LW-1:0]   o_sticky,
    output logic [LW-1:0]   o_leds
);

    localparam int PW = (LW > 1) ? clog2(LW) : 1;
    localparam logic [LW-1:0] UNLIT = LW'(unlit_pat(LW, ACTLOW));

    logic [LW-1:0] w_s;

    genvar gi;
    generate
        for (gi = 0; gi < LW; gi++) begin : g_sync
            proj_errmon_sync #(.SYNC(SYNC)) u_sync (
                .i_clk (i_clk),
                .i_rst (i_rst),
                .i_d   (i_errflg[gi]),
                .o_q   (w_s[gi])
            );
        end
    endgenerate

    logic [LW-1:0]  r_sticky;
    logic           r_errany;
    logic [HBW-1:0] r_tck;
    logic [0:0]     r_state;
    logic [PW-1:0]  r_ptr;
    logic           r_blink;
    logic [LW-1:0]  r_leds;

    logic [LW-1:0]  w_sticky_nxt;
    logic [0:0]     w_state_nxt;
    logic           w_xfer;
    logic           w_tick;
    logic [LW-1:0]  w_lit;

    assign w_sticky_nxt = (r_sticky & ~{LW{i_clr}}) | w_s;
    assign w_state_nxt  = (|w_sticky_nxt) ? ST_ALARM : ST_RUN;
    assign w_xfer       = (w_state_nxt != r_state);
    assign w_tick       = &r_tck;

    always_comb begin
        w_lit = '0;
        if (r_state == ST_RUN) begin
            w_lit[r_ptr] = 1'b1;
        end else begin
            // Live faults steady, latched-only faults follow the blink phase.
            w_lit = w_s | (r_sticky & {LW{r_blink}});
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sticky <= '0;
            r_errany <= 1'b0;
            r_tck    <= '0;
            r_state  <= ST_RUN;
            r_ptr    <= '0;
            r_blink  <= 1'b0;
            r_leds   <= UNLIT;
        end else begin
            r_sticky <= w_sticky_nxt;
            r_errany <= |w_sticky_nxt;
            r_tck    <= r_tck + HBW'(1);
            r_state  <= w_state_nxt;
            if (w_xfer) begin
                r_ptr   <= '0;
                r_blink <= 1'b0;
            end else if (w_tick) begin
                if (r_state == ST_RUN) begin
                    r_ptr <= (r_ptr == PW'(LW - 1)) ? '0 : r_ptr + PW'(1);
                end else begin
                    r_blink <= ~r_blink;
                end
            end
            r_leds <= w_lit ^ UNLIT;
        end
    end

    assign o_sticky = r_sticky;
    assign o_errany = r_errany;
    assign o_leds   = r_leds;

`ifdef PROJ_ERRMON_CNT_EN
    localparam int IDXW = PW;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c, input logic inc);
        if (inc && (c != {CW{1'b1}})) return c + CW'(1);
        return c;
    endfunction

    logic [LW-1:0] r_s_d;
    logic [LW-1:0] w_edge;
    logic [CW-1:0] r_cnt [LW];
    logic [CW-1:0] r_cntval;

    assign w_edge = w_s & ~r_s_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s_d    <= '0;
            r_cntval <= '0;
            for (int i = 0; i < LW; i++) r_cnt[i] <= '0;
        end else begin
            r_s_d <= w_s;
            // An edge coinciding with clr is kept as the first new event.
            for (int i = 0; i < LW; i++) begin
                r_cnt[i] <= i_clr ? CW'(w_edge[i]) : sat_inc(r_cnt[i], w_edge[i]);
            end
            r_cntval <= (i_cntsel < SELW'(LW)) ? r_cnt[i_cntsel[IDXW-1:0]] : '0;
        end
    end

    assign o_cntval = r_cntval;
`else
    logic w_cntsel_unused;
    assign w_cntsel_unused = ^i_cntsel;
    assign o_cntval        = '0;
`endif

endmodule
